// File: rtl/resta_serial.sv
// rtl/resta_serial.sv - bit-serial subtractor (A - B - Bin), LSB first, start/done handshake
module resta_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rd;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a;
    logic             b;
    logic             d;
    logic             br_next;

    // One-bit full-subtractor cell fed by the LSBs of the operand shifters.
    assign a       = ra[0];
    assign b       = rb[0];
    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra    <= A;
                        rb    <= B;
                        br    <= Bin;
                        rd    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rd  <= {d, rd[WIDTH-1:1]};
                    br  <= br_next;
                    cnt <= cnt + CW'(1);
                    // Last bit: publish the result on the same edge it completes.
                    if (cnt == LAST) begin
                        D     <= {d, rd[WIDTH-1:1]};
                        Bout  <= br_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_resta_serial.sv
// tb/tb_resta_serial.sv - directed and randomized checks of resta_serial against an arithmetic model
module tb_resta_serial;
    logic       clk = 1'b0;
    logic       rst;
    logic       s8, bin8, bo8, busy8, done8;
    logic [7:0] a8, b8, d8;
    logic       s3, bin3, bo3, busy3, done3;
    logic [2:0] a3, b3, d3;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] last_d8;
    logic       last_bo8;

    always #5 clk = ~clk;

    resta_serial #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .Bin(bin8),
        .D(d8), .Bout(bo8), .busy(busy8), .done(done8)
    );

    resta_serial #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(s3), .A(a3), .B(b3), .Bin(bin3),
        .D(d3), .Bout(bo3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input int w, input int a, input int b, input int bin);
        int diff;
        diff = a - b - bin;
        model = {1'b0, 8'((diff + 512) % (1 << w))};
        model[8] = (a < b + bin);
    endfunction

    // Full single operation on the 8-bit instance with cycle-accurate checks.
    task automatic op8(input int a, input int b, input int bin);
        logic [8:0] exp;
        exp = model(8, a, b, bin);
        @(negedge clk);
        s8 = 1'b1; a8 = 8'(a); b8 = 8'(b); bin8 = bin[0];
        @(posedge clk); #1;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        chk("start_busy", 32'(busy8), 32'd1);
        chk("start_done", 32'(done8), 32'd0);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (n < 8) begin
                chk("shift_busy", 32'(busy8), 32'd1);
                chk("shift_hold_d", 32'(d8), 32'(last_d8));
                chk("shift_hold_bout", 32'(bo8), 32'(last_bo8));
            end
        end
        chk("done_pulse", 32'(done8), 32'd1);
        chk("done_busy", 32'(busy8), 32'd0);
        chk("result_d", 32'(d8), 32'(exp[7:0]));
        chk("result_bout", 32'(bo8), 32'(exp[8]));
        last_d8 = exp[7:0];
        last_bo8 = exp[8];
        @(posedge clk); #1;
        chk("idle_done", 32'(done8), 32'd0);
        chk("idle_busy", 32'(busy8), 32'd0);
        chk("idle_hold_d", 32'(d8), 32'(last_d8));
    endtask

    initial begin
        int dones;
        logic [8:0] exp;
        rst = 1'b1;
        s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        s3 = 0; a3 = 0; b3 = 0; bin3 = 0;
        last_d8 = 0; last_bo8 = 0;
        #1;
        chk("reset_d", 32'(d8), 32'd0);
        chk("reset_bout", 32'(bo8), 32'd0);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        op8(100, 37, 0);
        op8(37, 100, 0);
        op8(0, 0, 1);
        op8(255, 255, 1);
        for (int i = 0; i < 20; i++)
            op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));

        // Continuous start: 5-3 then 3-5, operands switched during the DONE cycle.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd5; b8 = 8'd3; bin8 = 1'b0;
        @(posedge clk); #1;
        for (int n = 1; n <= 8; n++) begin @(posedge clk); #1; end
        chk("b2b_done1", 32'(done8), 32'd1);
        chk("b2b_d1", 32'(d8), 32'd2);
        chk("b2b_bout1", 32'(bo8), 32'd0);
        a8 = 8'd3; b8 = 8'd5;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            chk("b2b_busy2", 32'(busy8), 32'd1);
            chk("b2b_nodone2", 32'(done8), 32'd0);
            chk("b2b_hold_d", 32'(d8), 32'd2);
        end
        @(posedge clk); #1;
        s8 = 1'b0;
        chk("b2b_done2", 32'(done8), 32'd1);
        chk("b2b_d2", 32'(d8), 32'hFE);
        chk("b2b_bout2", 32'(bo8), 32'd1);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(busy8 | done8), 32'd0);

        // Start pulse mid-SHIFT must be ignored.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd200; b8 = 8'd55; bin8 = 1'b0;
        @(posedge clk); #1;
        s8 = 1'b0;
        dones = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            s8 = 1'b0;
            if (done8) dones++;
            if (n == 3) begin s8 = 1'b1; a8 = 8'd1; b8 = 8'd2; bin8 = 1'b1; end
            if (n == 8) begin
                chk("ignore_done", 32'(done8), 32'd1);
                chk("ignore_d", 32'(d8), 32'd145);
                chk("ignore_bout", 32'(bo8), 32'd0);
            end
        end
        chk("ignore_done_count", 32'(dones), 32'd1);

        // Reset during cycle 4 of SHIFT aborts.
        @(negedge clk);
        s8 = 1'b1; a8 = 8'd77; b8 = 8'd11; bin8 = 1'b0;
        @(posedge clk); #1;
        s8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_d", 32'(d8), 32'd0);
        chk("abort_bout", 32'(bo8), 32'd0);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dones++;
        end
        chk("abort_quiet", 32'(dones), 32'd0);
        last_d8 = 0; last_bo8 = 0;
        op8(9, 4, 0);

        // Exhaustive WIDTH=3 sweep, back-to-back.
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int bin = 0; bin < 2; bin++) begin
                    exp = model(3, a, b, bin);
                    @(negedge clk);
                    s3 = 1'b1; a3 = 3'(a); b3 = 3'(b); bin3 = bin[0];
                    @(posedge clk); #1;
                    s3 = 1'b0;
                    repeat (3) @(posedge clk);
                    #1;
                    chk("w3_done", 32'(done3), 32'd1);
                    chk("w3_d", 32'(d3), 32'(exp[2:0]));
                    chk("w3_bout", 32'(bo3), 32'(exp[8]));
                end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/resta_serial.md
# resta_serial

Bit-serial subtractor with a start/done handshake, the inverse arithmetic companion to the combinational one-bit adder `suma`. It latches two WIDTH-bit operands and a borrow-in, then computes `A - B - Bin` one bit per clock, LSB first, using a registered one-bit full-subtractor cell. It presents the WIDTH-bit difference and the borrow-out on held output registers. It sits beside the adder in the arithmetic exercises and trades throughput for a single-bit datapath.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: request a subtraction; sampled on the rising edge in IDLE or DONE only.
- `A` input WIDTH: minuend, captured on the accepting edge.
- `B` input WIDTH: subtrahend, captured on the accepting edge.
- `Bin` input 1: borrow-in, captured on the accepting edge.
- `D` output WIDTH: difference `(A - B - Bin) mod 2^WIDTH`, registered, held until the next completion.
- `Bout` output 1: borrow-out, 1 when `A < B + Bin` (unsigned), registered, held with `D`.
- `busy` output 1: high while the state is SHIFT.
- `done` output 1: single-cycle pulse, high while the state is DONE.

## Operation
- States:
  - IDLE (reset state).
  - SHIFT: WIDTH cycles of bit processing.
  - DONE: one cycle.
- IDLE -> SHIFT on `start`=1. Capture `A` and `B` into shift registers `ra` and `rb`, `Bin` into borrow flop `br`, and clear the bit counter `cnt` and the result shift register `rd`.
- In each SHIFT cycle, with `a=ra[0]`, `b=rb[0]`:
  - `d = a ^ b ^ br`
  - `br_next = (~a & b) | (~(a ^ b) & br)`
  - `ra`/`rb` shift right by one.
  - `d` is shifted into the MSB of `rd` (right shift).
  - `cnt` increments.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (`cnt == WIDTH-1`). On that same edge, `D` is loaded with the completed `{d, rd[WIDTH-1:1]}` and `Bout` with `br_next`.
- DONE -> SHIFT if `start`=1 (back-to-back, operands captured as in IDLE); otherwise DONE -> IDLE.
- `start` during SHIFT is ignored: no capture and no effect on the running operation.
- `D` and `Bout` change only at completion. They keep the previous result throughout SHIFT.
- `cnt` is wide enough for WIDTH-1, i.e. $clog2(WIDTH) bits, minimum 1.

## Timing
- Reset, asynchronous and effective immediately: state=IDLE; `D`=0, `Bout`=0, `busy`=0, `done`=0; `ra`, `rb`, `rd`, `br`, `cnt` cleared.
- Reset mid-SHIFT aborts the operation: no `done` pulse, and `D` and `Bout` return to 0.
- Latency: if `start` is sampled at edge E0, `busy`=1 from E0 through edge E0+WIDTH. At edge E0+WIDTH, `busy` falls, `done`=1, and `D`/`Bout` are valid. `done` falls at E0+WIDTH+1 unless a new start was sampled there; in that case `busy` rises again at that same edge.
- Throughput: one result per WIDTH+1 cycles with continuous `start`.
- `done` and `busy` are never high simultaneously.
- Operand inputs need only be stable at the accepting edge.

## Test plan
- WIDTH=8, A=100, B=37, Bin=0, pulse start -> `busy` for 8 cycles, then `done` for 1 cycle with D=63, Bout=0.
- WIDTH=8, A=37, B=100, Bin=0 -> D=0xC1 (193), Bout=1. Also A=0, B=0, Bin=1 -> D=0xFF, Bout=1. Also A=0xFF, B=0xFF, Bin=1 -> D=0xFF, Bout=1.
- Hold start high continuously with operands changed every DONE cycle (A=5,B=3 then A=3,B=5) -> D=2,Bout=0 then D=0xFE,Bout=1. Period is 9 cycles, and D holds 2 throughout the second SHIFT.
- Pulse start again mid-SHIFT with different operands -> ignored, first result unchanged, only one `done` pulse.
- Assert rst at cycle 4 of SHIFT -> outputs 0 immediately, no `done`. The next start with A=9, B=4 gives D=5, Bout=0.
- WIDTH=3 exhaustive sweep: all 128 combinations of A, B, Bin, each compared at `done` against D=(A-B-Bin) mod 8 and Bout=(A < B+Bin). Zero mismatches required.
